monitor_ctrl: RTL and testbench

Parametrised successor to the top-level byte monitor. Consumes a command byte stream from the receive FIFO and executes load, dump, checksum and exec against a blockram port, returning data and a status byte on a transmit stream. Adds generic address/length widths, a checksum command, a CPU start/halt handshake, an inter-byte timeout and explicit status codes. Sits between the UART FIFOs and the RAM/CPU.

---
 rtl/monitor_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_monitor_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_ctrl.sv
// Byte-stream monitor: parses load/dump/sum/exec commands from rx,
// drives a blockram port and the CPU launch handshake, answers on tx.
module monitor_ctrl #(
  parameter int          ADDR_WIDTH = 13,
  parameter int          ADDR_BYTES = 3,
  parameter int          LEN_WIDTH  = 16,
  parameter logic [23:0] TIMEOUT    = 24'd1200000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_din,
  output logic                  mem_we,
  output logic                  cpu_start,
  input  logic                  cpu_halted,
  output logic                  busy,
  output logic [3:0]            state_dbg
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    HDR       = 4'd1,
    DECODE    = 4'd2,
    LOAD_WAIT = 4'd3,
    LOAD_WR   = 4'd4,
    DUMP_RD   = 4'd5,
    DUMP_LAT  = 4'd6,
    DUMP_TX   = 4'd7,
    SUM_RD    = 4'd8,
    SUM_LAT   = 4'd9,
    SUM_ACC   = 4'd10,
    EXEC_W    = 4'd11,
    EXEC_RUN  = 4'd12,
    STATUS    = 4'd13
  } state_t;

  localparam logic [7:0] ST_OK  = 8'hA5;
  localparam logic [7:0] ST_BAD = 8'hE1;
  localparam logic [7:0] ST_TMO = 8'hE2;
  localparam logic [3:0] A_LAST = 4'(ADDR_BYTES);
  localparam logic [3:0] H_LAST = 4'(ADDR_BYTES + 2);

  state_t                state;
  logic [7:0]            cmd;
  logic [3:0]            hdr_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [15:0]           len_hdr;
  logic [7:0]            sum;
  logic                  sum_pend;
  logic                  ex_step;
  logic [23:0]           tmo_cnt;

  logic rx_xfer, tmo_hit, len_zero, len_last;
  logic is_load, is_dump, is_exec, is_sum, is_mem;

  assign rx_xfer  = rx_valid && rx_ready;
  assign tmo_hit  = (TIMEOUT != 24'd0) &&
                    (tmo_cnt == TIMEOUT - 24'd1);
  assign len_zero = (LEN_WIDTH'(len_hdr) == '0);
  assign len_last = (len == LEN_WIDTH'(1));
  assign is_load  = (cmd == 8'h01);
  assign is_dump  = (cmd == 8'h02);
  assign is_exec  = (cmd == 8'h03);
  assign is_sum   = (cmd == 8'h04);
  assign is_mem   = is_load || is_dump || is_sum;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      cmd       <= '0;
      hdr_cnt   <= '0;
      addr      <= '0;
      len       <= '0;
      len_hdr   <= '0;
      sum       <= '0;
      sum_pend  <= 1'b0;
      ex_step   <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      mem_we    <= 1'b0;
      cpu_start <= 1'b0;
      tmo_cnt   <= '0;
      case (state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (rx_xfer) begin
            cmd     <= rx_data;
            addr    <= '0;
            hdr_cnt <= 4'd1;
            state   <= HDR;
          end
        end
        HDR: begin
          if (rx_xfer) begin
            // last two header bytes end up in len_hdr
            len_hdr <= {len_hdr[7:0], rx_data};
            if (hdr_cnt <= A_LAST)
              addr <= ADDR_WIDTH'({addr, rx_data});
            hdr_cnt <= hdr_cnt + 4'd1;
            if (hdr_cnt == H_LAST) begin
              rx_ready <= 1'b0;
              state    <= DECODE;
            end
          end else if (tmo_hit) begin
            rx_ready <= 1'b0;
            tx_data  <= ST_TMO;
            tx_valid <= 1'b1;
            state    <= STATUS;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        DECODE: begin
          len      <= LEN_WIDTH'(len_hdr);
          sum      <= '0;
          sum_pend <= 1'b0;
          ex_step  <= 1'b0;
          unique case (1'b1)
            is_exec: begin
              mem_we    <= 1'b1;
              mem_waddr <= '0;
              mem_din   <= len_hdr[15:8];
              state     <= EXEC_W;
            end
            is_mem && len_zero: begin
              tx_data  <= ST_OK;
              tx_valid <= 1'b1;
              state    <= STATUS;
            end
            is_load && !len_zero: begin
              rx_ready <= 1'b1;
              state    <= LOAD_WAIT;
            end
            is_dump && !len_zero: begin
              mem_raddr <= addr;
              state     <= DUMP_RD;
            end
            is_sum && !len_zero: begin
              mem_raddr <= addr;
              state     <= SUM_RD;
            end
            default: begin
              tx_data  <= ST_BAD;
              tx_valid <= 1'b1;
              state    <= STATUS;
            end
          endcase
        end
        LOAD_WAIT: begin
          if (rx_xfer) begin
            mem_we    <= 1'b1;
            mem_waddr <= addr;
            mem_din   <= rx_data;
            rx_ready  <= 1'b0;
            state     <= LOAD_WR;
          end else if (tmo_hit) begin
            rx_ready <= 1'b0;
            tx_data  <= ST_TMO;
            tx_valid <= 1'b1;
            state    <= STATUS;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
        LOAD_WR: begin
          addr <= addr + ADDR_WIDTH'(1);
          len  <= len - LEN_WIDTH'(1);
          if (len_last) begin
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= STATUS;
          end else begin
            rx_ready <= 1'b1;
            state    <= LOAD_WAIT;
          end
        end
        DUMP_RD:  state <= DUMP_LAT;
        DUMP_LAT: begin
          tx_data  <= mem_dout;
          tx_valid <= 1'b1;
          state    <= DUMP_TX;
        end
        DUMP_TX: begin
          if (tx_ready) begin
            addr <= addr + ADDR_WIDTH'(1);
            len  <= len - LEN_WIDTH'(1);
            if (len_last) begin
              tx_data <= ST_OK;
              state   <= STATUS;
            end else begin
              tx_valid  <= 1'b0;
              mem_raddr <= addr + ADDR_WIDTH'(1);
              state     <= DUMP_RD;
            end
          end
        end
        SUM_RD:  state <= SUM_LAT;
        SUM_LAT: state <= SUM_ACC;
        SUM_ACC: begin
          sum  <= sum + mem_dout;
          addr <= addr + ADDR_WIDTH'(1);
          len  <= len - LEN_WIDTH'(1);
          if (len_last) begin
            tx_data  <= sum + mem_dout;
            tx_valid <= 1'b1;
            sum_pend <= 1'b1;
            state    <= STATUS;
          end else begin
            mem_raddr <= addr + ADDR_WIDTH'(1);
            state     <= SUM_RD;
          end
        end
        EXEC_W: begin
          if (!ex_step) begin
            mem_we    <= 1'b1;
            mem_waddr <= ADDR_WIDTH'(1);
            mem_din   <= len_hdr[7:0];
            ex_step   <= 1'b1;
          end else begin
            cpu_start <= 1'b1;
            state     <= EXEC_RUN;
          end
        end
        EXEC_RUN: begin
          // skip the pulse cycle so a stale halt level cannot end the run
          if (cpu_halted && !cpu_start) begin
            tx_data  <= ST_OK;
            tx_valid <= 1'b1;
            state    <= STATUS;
          end
        end
        STATUS: begin
          if (tx_ready) begin
            if (sum_pend) begin
              tx_data  <= ST_OK;
              sum_pend <= 1'b0;
            end else begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monitor_ctrl.sv
// Bench for monitor_ctrl: command table plus exec, timeout and
// reset corner sequences, tx bytes checked against a scoreboard.
module tb_monitor_ctrl;

  localparam int TMO = 40;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [12:0] mem_raddr;
  logic [7:0]  mem_dout;
  logic [12:0] mem_waddr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        cpu_start;
  logic        cpu_halted;
  logic        busy;
  logic [3:0]  state_dbg;

  monitor_ctrl #(
    .ADDR_WIDTH(13),
    .ADDR_BYTES(3),
    .LEN_WIDTH (16),
    .TIMEOUT   (24'(TMO))
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mem_raddr (mem_raddr),
    .mem_dout  (mem_dout),
    .mem_waddr (mem_waddr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .cpu_start (cpu_start),
    .cpu_halted(cpu_halted),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_din;
    mem_dout <= mem[mem_raddr];
  end

  wire [50:0] all_outs = {rx_ready, tx_data, tx_valid,
    mem_raddr, mem_waddr, mem_din, mem_we, cpu_start,
    busy, state_dbg};

  typedef struct packed {
    logic [3:0]  n_rx;
    logic [79:0] rx;
    logic [2:0]  n_tx;
    logic [31:0] tx;
    logic [3:0]  n_we;
    logic [1:0]  stall;
  } vec_t;

  vec_t       vecs [9];
  logic [7:0] exp_q [$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int we_cnt = 0;
  int start_cnt = 0;
  int conflict = 0;
  int stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (!rst) begin
      if (rx_ready && tx_valid) conflict++;
      if (prev_stall && (!tx_valid || tx_data != prev_data))
        stab_err++;
      if (mem_we) we_cnt++;
      if (cpu_start) start_cnt++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%0h required=none",
                   tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 64'(tx_data), 64'(e));
        end
      end
    end
    prev_stall = !rst && tx_valid && !tx_ready;
    prev_data  = tx_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    tx_ready = (rdy_mode == 0) ? 1'b1 :
               (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("rx_ready_wait", 64'(n), 64'd0);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    chk(name, 64'(n < 3000), 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int we0;
    we0 = we_cnt;
    rdy_mode = int'(v.stall);
    for (int i = 0; i < int'(v.n_tx); i++)
      exp_q.push_back(v.tx[31-8*i -: 8]);
    for (int i = 0; i < int'(v.n_rx); i++)
      send_byte(v.rx[79-8*i -: 8]);
    wait_idle("vec_done");
    chk("vec_we_count", 64'(we_cnt - we0), 64'(v.n_we));
    rdy_mode = 0;
  endtask

  initial begin
    int n;
    int s0;
    int we0;
    vec_t v;
    vecs[0] = '{4'd9, 80'h01_00_00_10_00_03_AA_BB_CC_00,
                3'd1, 32'hA5000000, 4'd3, 2'd0};
    vecs[1] = '{4'd6, 80'h02_00_00_10_00_03_00_00_00_00,
                3'd4, 32'hAABBCCA5, 4'd0, 2'd1};
    vecs[2] = '{4'd7, 80'h01_00_1F_FF_00_01_F0_00_00_00,
                3'd1, 32'hA5000000, 4'd1, 2'd0};
    vecs[3] = '{4'd7, 80'h01_00_00_00_00_01_20_00_00_00,
                3'd1, 32'hA5000000, 4'd1, 2'd0};
    vecs[4] = '{4'd6, 80'h04_00_1F_FF_00_02_00_00_00_00,
                3'd2, 32'h10A50000, 4'd0, 2'd1};
    vecs[5] = '{4'd6, 80'h07_00_00_00_00_00_00_00_00_00,
                3'd1, 32'hE1000000, 4'd0, 2'd0};
    vecs[6] = '{4'd6, 80'h02_00_00_10_00_00_00_00_00_00,
                3'd1, 32'hA5000000, 4'd0, 2'd0};
    vecs[7] = '{4'd6, 80'h02_FF_E0_11_00_02_00_00_00_00,
                3'd3, 32'hBBCCA500, 4'd0, 2'd0};
    vecs[8] = '{4'd6, 80'h04_00_00_10_00_00_00_00_00_00,
                3'd1, 32'hA5000000, 4'd0, 2'd0};

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    tx_ready = 1'b1;
    cpu_halted = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'(all_outs), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_rx_ready", 64'(rx_ready), 64'd1);
    chk("idle_state", 64'(state_dbg), 64'd0);

    foreach (vecs[k]) run_vec(vecs[k]);
    chk("mem_10", 64'(mem[16]), 64'hAA);
    chk("mem_11", 64'(mem[17]), 64'hBB);
    chk("mem_12", 64'(mem[18]), 64'hCC);
    chk("mem_1fff", 64'(mem[8191]), 64'hF0);

    s0 = start_cnt;
    we0 = we_cnt;
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (100) tick();
    chk("exec_start_pulses", 64'(start_cnt - s0), 64'd1);
    chk("exec_we_count", 64'(we_cnt - we0), 64'd2);
    chk("exec_mem0", 64'(mem[0]), 64'h12);
    chk("exec_mem1", 64'(mem[1]), 64'h34);
    chk("exec_run_state", 64'(state_dbg), 64'd12);
    chk("exec_no_tx", 64'(tx_valid), 64'd0);
    exp_q.push_back(8'hA5);
    cpu_halted = 1'b1;
    wait_idle("exec_done");
    cpu_halted = 1'b0;

    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'hAA);
    n = 0;
    while (!tx_valid && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_latency_ok",
        64'(n >= TMO && n <= TMO + 4), 64'd1);
    chk("tmo_code", 64'(tx_data), 64'hE2);
    exp_q.push_back(8'hE2);
    wait_idle("tmo_done");
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_partial_mem0", 64'(mem[0]), 64'hAA);
    v = '{4'd6, 80'h02_00_00_00_00_01_00_00_00_00,
          3'd2, 32'hAAA50000, 4'd0, 2'd0};
    run_vec(v);

    rdy_mode = 2;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    send_byte(8'h03);
    n = 0;
    while (!tx_valid && n < 50) begin
      tick();
      n++;
    end
    chk("stall_tx_valid", 64'(tx_valid), 64'd1);
    chk("stall_tx_data", 64'(tx_data), 64'hAA);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midreset_outputs", 64'(all_outs), 64'd0);
    tick();
    rst = 1'b0;
    rdy_mode = 0;
    repeat (20) tick();
    chk("post_reset_state", 64'(state_dbg), 64'd0);
    chk("post_reset_tx", 64'(tx_valid), 64'd0);
    chk("post_reset_rx_ready", 64'(rx_ready), 64'd1);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("rx_tx_conflict", 64'(conflict), 64'd0);
    chk("tx_stall_stable", 64'(stab_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
